// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC,
// NOP word, IF/ID payload and the fetch-window check.
package fetch_unit_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [XLEN-1:0] FU_RESET_PC = 32'h0000_3000;
   localparam logic [XLEN-1:0] NOP_WORD    = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } ifid_t;

   // True when pc is word aligned and inside [first, last].
   function automatic logic pc_in_range(input logic [XLEN-1:0] pc,
                                        input logic [XLEN-1:0] first,
                                        input logic [XLEN-1:0] last);
      return (pc[1:0] == 2'b00) && (pc >= first) && (pc <= last);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: pipeline control in, instruction-memory port, IF/ID outputs.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic            stall;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] fu_pc;
   logic [XLEN-1:0] fu_instr;
   logic [XLEN-1:0] ifid_instr;
   logic [XLEN-1:0] ifid_pc;
   logic [XLEN-1:0] ifid_pc8;
   logic            ifid_valid;
   logic            halted;
   logic            addr_err;

   modport master (
      input  stall, redirect, redirect_pc, fu_instr,
      output fu_pc, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, halted, addr_err
   );

   modport slave (
      output stall, redirect, redirect_pc, fu_instr,
      input  fu_pc, ifid_instr, ifid_pc, ifid_pc8, ifid_valid, halted, addr_err
   );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register. flush wins over en and writes a bubble; the bubble
// still takes the new pc when en is also set, otherwise pc is held.
module ifid_reg
   import fetch_unit_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  en,
   input  logic  flush,
   input  ifid_t d,
   output ifid_t q,
   output logic  valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         q.instr <= NOP_WORD;
         valid   <= 1'b0;
         if (en) q.pc <= d.pc;
      end else if (en) begin
         q     <= d;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, fetch-window check and BOOT/RUN/HALT FSM.
// Define DELAY_SLOT_EN to let the instruction after a taken redirect execute.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = FU_RESET_PC,
   parameter int unsigned     IM_WORDS = 1024
)(
   input logic         clk,
   input logic         reset,
   fetch_unit_if.master fu
);

   localparam logic [XLEN-1:0] PC_LAST = RESET_PC + XLEN'(4 * (IM_WORDS - 1));

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            halted_q, halted_d;
   logic            addr_err_q, addr_err_d;
   logic [XLEN-1:0] pc_tgt_c;
   logic            ifid_en_c;
   logic            ifid_flush_c;
   ifid_t           ifid_d;
   ifid_t           ifid_q;

   assign pc_tgt_c = fu.redirect ? fu.redirect_pc : pc_q + XLEN'(4);
   assign ifid_d   = '{instr: fu.fu_instr, pc: pc_q};

   // Next state, next PC and IF/ID control. BOOT fetches RESET_PC exactly like RUN.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      halted_d     = halted_q;
      addr_err_d   = addr_err_q;
      ifid_en_c    = 1'b0;
      ifid_flush_c = 1'b0;
      case (state_q)
         ST_BOOT, ST_RUN: begin
            state_d = ST_RUN;
            if (!fu.stall) begin
               ifid_en_c = 1'b1;
`ifdef DELAY_SLOT_EN
               ifid_flush_c = 1'b0;
`else
               ifid_flush_c = fu.redirect;
`endif
               if (pc_in_range(pc_tgt_c, RESET_PC, PC_LAST)) begin
                  pc_d = pc_tgt_c;
               end else begin
                  // Current fetch completes; the bad target is never loaded.
                  state_d    = ST_HALT;
                  halted_d   = 1'b1;
                  addr_err_d = 1'b1;
               end
            end
         end
         ST_HALT: begin
            ifid_flush_c = 1'b1;
         end
         default: begin
            state_d      = ST_HALT;
            halted_d     = 1'b1;
            ifid_flush_c = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         halted_q   <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         halted_q   <= halted_d;
         addr_err_q <= addr_err_d;
      end
   end

   ifid_reg u_ifid_reg (
      .clk   (clk),
      .reset (reset),
      .en    (ifid_en_c),
      .flush (ifid_flush_c),
      .d     (ifid_d),
      .q     (ifid_q),
      .valid (fu.ifid_valid)
   );

   assign fu.fu_pc      = pc_q;
   assign fu.halted     = halted_q;
   assign fu.addr_err   = addr_err_q;
   assign fu.ifid_instr = ifid_q.instr;
   assign fu.ifid_pc    = ifid_q.pc;
   assign fu.ifid_pc8   = ifid_q.pc + XLEN'(8);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

   localparam logic [31:0] RP  = 32'h0000_3000;
   localparam int          IMW = 1024;
`ifdef DELAY_SLOT_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] salt = 32'h0;

   always #5 clk = ~clk;

   fetch_unit_if fu();
   assign fu.fu_instr = fu.fu_pc ^ salt;

   fetch_unit #(.RESET_PC(RP), .IM_WORDS(IMW)) dut (
      .clk   (clk),
      .reset (reset),
      .fu    (fu.master)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_instr, m_ipc;
   bit          m_valid, m_halted, m_err;

   function automatic bit legal(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(RP);
      return (off >= 0) && (off % 4 == 0) && (off / 4 < IMW);
   endfunction

   // Drives one cycle of inputs, advances the model and lands #1 after the edge.
   task automatic tick(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
      logic [31:0] n_pc, n_i, n_p, tgt;
      bit          n_v, n_h, n_e;
      reset = rst; fu.stall = st; fu.redirect = rd; fu.redirect_pc = rpc;
      n_pc = m_pc; n_i = m_instr; n_p = m_ipc; n_v = m_valid; n_h = m_halted; n_e = m_err;
      if (rst) begin
         n_pc = RP; n_i = 0; n_p = 0; n_v = 0; n_h = 0; n_e = 0;
      end else if (m_halted) begin
         n_i = 0; n_v = 0;
      end else if (!st) begin
         tgt = rd ? rpc : m_pc + 32'd4;
         n_p = m_pc;
         if (rd && !DS) begin n_i = 0; n_v = 0; end
         else begin n_i = m_pc ^ salt; n_v = 1; end
         if (legal(tgt)) n_pc = tgt;
         else begin n_h = 1; n_e = 1; end
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_i; m_ipc = n_p; m_valid = n_v; m_halted = n_h; m_err = n_e;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b1, 1'b1, 32'h0000_3040);
      tick(1'b1, 1'b0, 1'b1, 32'h0000_3042);
      checks++; if (fu.fu_pc !== RP) begin errors++; $display("FAIL reset_pc got %h exp %h", fu.fu_pc, RP); end
      checks++; if (fu.ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", fu.ifid_instr); end
      checks++; if (fu.ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid_pc got %h exp 0", fu.ifid_pc); end
      checks++; if ({fu.ifid_valid, fu.halted, fu.addr_err} !== 3'b000)
         begin errors++; $display("FAIL reset_flags got %b exp 000", {fu.ifid_valid, fu.halted, fu.addr_err}); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (fu.ifid_pc !== 32'h3000 || fu.ifid_valid !== 1'b1)
         begin errors++; $display("FAIL boot_fetch got pc %h v %b exp 3000 1", fu.ifid_pc, fu.ifid_valid); end
      for (int k = 1; k < 3; k++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0);
         exp_pc = 32'h3000 + 32'(4 * k);
         checks++; if (fu.ifid_pc !== exp_pc || fu.ifid_instr !== exp_pc || fu.ifid_valid !== 1'b1)
            begin errors++; $display("FAIL seq_ifid got %h/%h/%b exp %h", fu.ifid_pc, fu.ifid_instr, fu.ifid_valid, exp_pc); end
         checks++; if (fu.ifid_pc8 !== exp_pc + 32'd8)
            begin errors++; $display("FAIL seq_pc8 got %h exp %h", fu.ifid_pc8, exp_pc + 32'd8); end
      end
      checks++; if (fu.fu_pc !== 32'h300C) begin errors++; $display("FAIL seq_fu_pc got %h exp 300c", fu.fu_pc); end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1, k[0], 32'h0000_3100);
         checks++; if (fu.fu_pc !== 32'h300C || fu.ifid_pc !== 32'h3008 || fu.ifid_valid !== 1'b1)
            begin errors++; $display("FAIL stall_hold got pc %h ifid %h v %b exp 300c 3008 1", fu.fu_pc, fu.ifid_pc, fu.ifid_valid); end
      end
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (fu.fu_pc !== 32'h3010 || fu.ifid_pc !== 32'h300C)
         begin errors++; $display("FAIL stall_resume got pc %h ifid %h exp 3010 300c", fu.fu_pc, fu.ifid_pc); end
   endtask

   task automatic test_redirect();
      tick(1'b0, 1'b0, 1'b1, 32'h0000_3040);
      checks++; if (fu.fu_pc !== 32'h3040) begin errors++; $display("FAIL redir_pc got %h exp 3040", fu.fu_pc); end
      checks++; if (fu.ifid_pc !== 32'h3010 || fu.ifid_valid !== DS || fu.ifid_instr !== (DS ? 32'h3010 : 32'h0))
         begin errors++; $display("FAIL redir_slot got %h/%h/%b exp 3010 valid %b", fu.ifid_pc, fu.ifid_instr, fu.ifid_valid, DS); end
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (fu.ifid_pc !== 32'h3040 || fu.ifid_valid !== 1'b1 || fu.fu_pc !== 32'h3044)
         begin errors++; $display("FAIL redir_target got %h/%b pc %h exp 3040 1 3044", fu.ifid_pc, fu.ifid_valid, fu.fu_pc); end
   endtask

   task automatic test_stall_redirect();
      tick(1'b0, 1'b1, 1'b1, 32'h0000_3080);
      checks++; if (fu.fu_pc !== 32'h3044 || fu.ifid_pc !== 32'h3040)
         begin errors++; $display("FAIL stall_redir_hold got pc %h ifid %h exp 3044 3040", fu.fu_pc, fu.ifid_pc); end
      tick(1'b0, 1'b0, 1'b1, 32'h0000_3080);
      checks++; if (fu.fu_pc !== 32'h3080) begin errors++; $display("FAIL stall_redir_take got %h exp 3080", fu.fu_pc); end
   endtask

   task automatic test_misaligned();
      tick(1'b0, 1'b0, 1'b1, 32'h0000_3042);
      checks++; if (fu.halted !== 1'b1 || fu.addr_err !== 1'b1 || fu.fu_pc !== 32'h3080)
         begin errors++; $display("FAIL misal_halt got h %b e %b pc %h exp 1 1 3080", fu.halted, fu.addr_err, fu.fu_pc); end
      tick(1'b0, 1'b0, 1'b1, 32'h0000_3000);
      checks++; if (fu.ifid_valid !== 1'b0 || fu.ifid_instr !== 32'h0 || fu.fu_pc !== 32'h3080 || fu.halted !== 1'b1)
         begin errors++; $display("FAIL halt_bubble got v %b i %h pc %h h %b", fu.ifid_valid, fu.ifid_instr, fu.fu_pc, fu.halted); end
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (fu.halted !== 1'b0 || fu.addr_err !== 1'b0 || fu.fu_pc !== RP)
         begin errors++; $display("FAIL halt_reset got h %b e %b pc %h exp 0 0 3000", fu.halted, fu.addr_err, fu.fu_pc); end
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (fu.ifid_pc !== 32'h3000 || fu.ifid_valid !== 1'b1 || fu.fu_pc !== 32'h3004)
         begin errors++; $display("FAIL restart got %h/%b pc %h exp 3000 1 3004", fu.ifid_pc, fu.ifid_valid, fu.fu_pc); end
   endtask

   task automatic test_end_of_range();
      int n;
      tick(1'b0, 1'b0, 1'b1, 32'h0000_3FF0);
      n = 0;
      while (!fu.halted && n < 10) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0);
         n++;
      end
      checks++; if (n != 4) begin errors++; $display("FAIL eor_cycles got %0d exp 4", n); end
      checks++; if (fu.halted !== 1'b1 || fu.addr_err !== 1'b1 || fu.fu_pc !== 32'h3FFC || fu.ifid_pc !== 32'h3FFC)
         begin errors++; $display("FAIL eor_state got h %b e %b pc %h ifid %h exp 1 1 3ffc 3ffc", fu.halted, fu.addr_err, fu.fu_pc, fu.ifid_pc); end
   endtask

   task automatic test_random();
      logic [31:0] rpc;
      bit          rst;
      salt = $urandom;
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      for (int k = 0; k < 400; k++) begin
         case ($urandom % 8)
            0:       rpc = RP + 32'(4 * $urandom_range(0, IMW - 1)) + 32'($urandom_range(1, 3));
            1:       rpc = $urandom;
            2:       rpc = RP + 32'(4 * (IMW - 1 - $urandom_range(0, 3)));
            default: rpc = RP + 32'(4 * $urandom_range(0, IMW - 1));
         endcase
         rst = m_halted ? ($urandom % 4 == 0) : ($urandom % 64 == 0);
         if (k % 50 == 25) salt = $urandom;
         tick(rst, ($urandom % 4 == 0), ($urandom % 5 == 0), rpc);
         checks++; if (fu.fu_pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", k, fu.fu_pc, m_pc); end
         checks++; if (fu.ifid_instr !== m_instr) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", k, fu.ifid_instr, m_instr); end
         checks++; if (fu.ifid_pc !== m_ipc || fu.ifid_pc8 !== m_ipc + 32'd8)
            begin errors++; $display("FAIL rnd_ifid_pc cyc %0d got %h/%h exp %h", k, fu.ifid_pc, fu.ifid_pc8, m_ipc); end
         checks++; if ({fu.ifid_valid, fu.halted, fu.addr_err} !== {m_valid, m_halted, m_err})
            begin errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", k, {fu.ifid_valid, fu.halted, fu.addr_err}, {m_valid, m_halted, m_err}); end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_stall_redirect();
      test_misaligned();
      test_end_of_range();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
